// File: rtl/ariane_xilinx.sv
// Reduced VCU128 bring-up shell for the Ariane FPGA top: reset generation, status LEDs,
// UART echo and an IDCODE/BYPASS JTAG TAP oversampled on sys_clk; all memory/network pins parked.
module ariane_xilinx #(
    parameter int          CLKS_PER_BIT = 868,
    parameter int          HB_BITS      = 24,
    parameter logic [31:0] IDCODE       = 32'h249511C3
) (
    input  logic        sys_clk_p,
    input  logic        sys_clk_n,
    input  logic        cpu_reset,
    input  logic        sys_rst_n,
    input  logic        trst_n,
    output logic [7:0]  led,
    input  logic        rx,
    output logic        tx,
    input  logic        tck,
    input  logic        tms,
    input  logic        tdi,
    output logic        tdo,
    output logic [16:0] c0_ddr4_adr,
    output logic [1:0]  c0_ddr4_ba,
    output logic [0:0]  c0_ddr4_cke,
    output logic [1:0]  c0_ddr4_cs_n,
    output logic [0:0]  c0_ddr4_odt,
    output logic [0:0]  c0_ddr4_bg,
    output logic        c0_ddr4_reset_n,
    output logic        c0_ddr4_act_n,
    output logic [0:0]  c0_ddr4_ck_t,
    output logic [0:0]  c0_ddr4_ck_c,
    inout  wire  [71:0] c0_ddr4_dq,
    inout  wire  [8:0]  c0_ddr4_dqs_t,
    inout  wire  [8:0]  c0_ddr4_dqs_c,
    inout  wire  [8:0]  c0_ddr4_dm_dbi_n,
    output logic        eth_rst_n,
    output logic        eth_sgmii_tx_p,
    output logic        eth_sgmii_tx_n,
    output logic        eth_mdc,
    inout  wire         eth_mdio,
    input  logic        eth_sgmii_rxck_p,
    input  logic        eth_sgmii_rxck_n,
    input  logic        eth_sgmii_rx_p,
    input  logic        eth_sgmii_rx_n,
    input  logic        eth_int_n,
    output logic        spi_mosi,
    output logic        spi_ss,
    output logic        spi_clk_o,
    input  logic        spi_miso
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [4:0]    IR_IDCODE = 5'b00001;

    logic clk;
    logic rst_a, rst;
    logic [1:0] rst_sync;
    logic periph_rst_n;
    logic [HB_BITS:0] hb_cnt;
    logic unused_inputs;

    assign clk   = sys_clk_p;
    assign rst_a = cpu_reset | ~sys_rst_n;
    assign rst   = rst_sync[1];
    assign unused_inputs = ^{sys_clk_n, eth_sgmii_rxck_p, eth_sgmii_rxck_n,
                             eth_sgmii_rx_p, eth_sgmii_rx_n, eth_int_n, spi_miso};

    always_ff @(posedge clk or posedge rst_a) begin
        if (rst_a) rst_sync <= 2'b11;
        else       rst_sync <= {rst_sync[0], 1'b0};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            periph_rst_n <= 1'b0;
            hb_cnt       <= '0;
        end else begin
            periph_rst_n <= 1'b1;
            hb_cnt       <= hb_cnt + 1'b1;
        end
    end

    assign c0_ddr4_reset_n  = periph_rst_n;
    assign eth_rst_n        = periph_rst_n;
    assign c0_ddr4_adr      = '0;
    assign c0_ddr4_ba       = '0;
    assign c0_ddr4_cke      = '0;
    assign c0_ddr4_cs_n     = '1;
    assign c0_ddr4_odt      = '0;
    assign c0_ddr4_bg       = '0;
    assign c0_ddr4_act_n    = 1'b1;
    assign c0_ddr4_ck_t     = '0;
    assign c0_ddr4_ck_c     = '1;
    assign c0_ddr4_dq       = 'z;
    assign c0_ddr4_dqs_t    = 'z;
    assign c0_ddr4_dqs_c    = 'z;
    assign c0_ddr4_dm_dbi_n = 'z;
    assign eth_sgmii_tx_p   = 1'b0;
    assign eth_sgmii_tx_n   = 1'b1;
    assign eth_mdc          = 1'b0;
    assign eth_mdio         = 1'bz;
    assign spi_ss           = 1'b1;
    assign spi_clk_o        = 1'b0;
    assign spi_mosi         = 1'b0;

    // UART receiver
    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
    rx_state_t rx_state, rx_next;
    logic [2:0] rx_sync;
    logic rx_s, rx_prev, rx_half, rx_full, rx_valid;
    logic [CW-1:0] rx_cnt;
    logic [2:0] rx_bits;
    logic [7:0] rx_shift;
    logic [3:0] rx_nib;

    assign rx_s    = rx_sync[1];
    assign rx_prev = rx_sync[2];
    assign rx_half = (rx_cnt == HALF_LAST);
    assign rx_full = (rx_cnt == BIT_LAST);

    always_comb begin
        rx_next  = rx_state;
        rx_valid = 1'b0;
        case (rx_state)
            RX_IDLE:  if (rx_prev && !rx_s) rx_next = RX_START;
            RX_START: if (rx_half) rx_next = rx_s ? RX_IDLE : RX_DATA;
            RX_DATA:  if (rx_full && rx_bits == 3'd7) rx_next = RX_STOP;
            RX_STOP: begin
                if (rx_full) begin
                    rx_next  = RX_IDLE;
                    rx_valid = rx_s;
                end
            end
            default:  rx_next = RX_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_sync  <= '1;
            rx_state <= RX_IDLE;
            rx_cnt   <= '0;
            rx_bits  <= '0;
            rx_shift <= '0;
            rx_nib   <= '0;
        end else begin
            rx_sync  <= {rx_sync[1:0], rx};
            rx_state <= rx_next;
            if (rx_state == RX_IDLE || rx_state != rx_next || rx_full) rx_cnt <= '0;
            else                                                       rx_cnt <= rx_cnt + 1'b1;
            if (rx_state == RX_START) rx_bits <= '0;
            if (rx_state == RX_DATA && rx_full) begin
                rx_shift <= {rx_s, rx_shift[7:1]};
                rx_bits  <= rx_bits + 1'b1;
            end
            if (rx_valid) rx_nib <= rx_shift[3:0];
        end
    end

    // Echo transmitter: the frame shifter doubles as the one-byte holding register
    logic tx_busy, overrun;
    logic [9:0] tx_shift;
    logic [CW-1:0] tx_cnt;
    logic [3:0] tx_bits;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_busy  <= 1'b0;
            tx_shift <= '1;
            tx_cnt   <= '0;
            tx_bits  <= '0;
            overrun  <= 1'b0;
        end else begin
            if (rx_valid && tx_busy) overrun <= 1'b1;
            if (rx_valid && !tx_busy) begin
                tx_busy  <= 1'b1;
                tx_shift <= {1'b1, rx_shift, 1'b0};
                tx_cnt   <= '0;
                tx_bits  <= '0;
            end else if (tx_busy) begin
                if (tx_cnt == BIT_LAST) begin
                    tx_cnt   <= '0;
                    tx_shift <= {1'b1, tx_shift[9:1]};
                    tx_bits  <= tx_bits + 1'b1;
                    if (tx_bits == 4'd9) tx_busy <= 1'b0;
                end else begin
                    tx_cnt <= tx_cnt + 1'b1;
                end
            end
        end
    end

    assign tx = tx_busy ? tx_shift[0] : 1'b1;

    // JTAG TAP
    typedef enum logic [3:0] {
        TLR, RTI, SEL_DR, CAP_DR, SH_DR, EX1_DR, PAU_DR, EX2_DR, UPD_DR,
        SEL_IR, CAP_IR, SH_IR, EX1_IR, PAU_IR, EX2_IR, UPD_IR
    } tap_state_t;
    tap_state_t tap_state, tap_next;
    logic [2:0] tck_sync;
    logic [1:0] tms_sync, tdi_sync;
    logic tck_rise, tck_fall, tms_s, tdi_s, tap_rst, sel_id, tdo_next;
    logic [4:0] ir, ir_sh;
    logic [31:0] dr;
    logic bypass_q;

    assign tck_rise = tck_sync[1] & ~tck_sync[2];
    assign tck_fall = ~tck_sync[1] & tck_sync[2];
    assign tms_s    = tms_sync[1];
    assign tdi_s    = tdi_sync[1];
    assign tap_rst  = rst | ~trst_n;
    assign sel_id   = (ir == IR_IDCODE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tck_sync <= '0;
            tms_sync <= '0;
            tdi_sync <= '0;
        end else begin
            tck_sync <= {tck_sync[1:0], tck};
            tms_sync <= {tms_sync[0], tms};
            tdi_sync <= {tdi_sync[0], tdi};
        end
    end

    always_comb begin
        tap_next = tap_state;
        if (tck_rise) begin
            case (tap_state)
                TLR:     tap_next = tms_s ? TLR    : RTI;
                RTI:     tap_next = tms_s ? SEL_DR : RTI;
                SEL_DR:  tap_next = tms_s ? SEL_IR : CAP_DR;
                CAP_DR:  tap_next = tms_s ? EX1_DR : SH_DR;
                SH_DR:   tap_next = tms_s ? EX1_DR : SH_DR;
                EX1_DR:  tap_next = tms_s ? UPD_DR : PAU_DR;
                PAU_DR:  tap_next = tms_s ? EX2_DR : PAU_DR;
                EX2_DR:  tap_next = tms_s ? UPD_DR : SH_DR;
                UPD_DR:  tap_next = tms_s ? SEL_DR : RTI;
                SEL_IR:  tap_next = tms_s ? TLR    : CAP_IR;
                CAP_IR:  tap_next = tms_s ? EX1_IR : SH_IR;
                SH_IR:   tap_next = tms_s ? EX1_IR : SH_IR;
                EX1_IR:  tap_next = tms_s ? UPD_IR : PAU_IR;
                PAU_IR:  tap_next = tms_s ? EX2_IR : PAU_IR;
                EX2_IR:  tap_next = tms_s ? UPD_IR : SH_IR;
                UPD_IR:  tap_next = tms_s ? SEL_DR : RTI;
                default: tap_next = TLR;
            endcase
        end
    end

    always_comb begin
        tdo_next = 1'b0;
        if (tap_state == SH_IR)      tdo_next = ir_sh[0];
        else if (tap_state == SH_DR) tdo_next = sel_id ? dr[0] : bypass_q;
    end

    always_ff @(posedge clk or posedge tap_rst) begin
        if (tap_rst) begin
            tap_state <= TLR;
            ir        <= IR_IDCODE;
            ir_sh     <= '0;
            dr        <= '0;
            bypass_q  <= 1'b0;
            tdo       <= 1'b0;
        end else begin
            tap_state <= tap_next;
            if (tck_rise) begin
                case (tap_state)
                    TLR:    ir    <= IR_IDCODE;
                    CAP_IR: ir_sh <= IR_IDCODE;
                    SH_IR:  ir_sh <= {tdi_s, ir_sh[4:1]};
                    UPD_IR: ir    <= ir_sh;
                    CAP_DR: if (sel_id) dr <= IDCODE; else bypass_q <= 1'b0;
                    SH_DR:  if (sel_id) dr <= {tdi_s, dr[31:1]}; else bypass_q <= tdi_s;
                    default: ;
                endcase
            end
            if (tck_fall) tdo <= tdo_next;
        end
    end

    assign led = {rx_nib, tap_state == SH_DR, overrun, rst, hb_cnt[HB_BITS]};
endmodule

// File: tb/tb_ariane_xilinx.sv
// Directed bench for the ariane_xilinx bring-up shell: reset/parked pins, heartbeat,
// UART echo vectors and JTAG IDCODE/BYPASS/TRST sequences.
module tb_ariane_xilinx;
    localparam int C = 16;
    localparam logic [31:0] ID = 32'h249511C3;

    logic sys_clk_p = 1'b0;
    logic sys_clk_n;
    logic cpu_reset, sys_rst_n;
    logic trst_n = 1'b1;
    logic rx = 1'b1;
    logic tck = 1'b0, tms = 1'b1, tdi = 1'b0;
    logic in_zero = 1'b0;
    logic [7:0] led;
    logic tx, tdo;
    logic [16:0] c0_ddr4_adr;
    logic [1:0] c0_ddr4_ba, c0_ddr4_cs_n;
    logic [0:0] c0_ddr4_cke, c0_ddr4_odt, c0_ddr4_bg, c0_ddr4_ck_t, c0_ddr4_ck_c;
    logic c0_ddr4_reset_n, c0_ddr4_act_n;
    wire [71:0] c0_ddr4_dq;
    wire [8:0] c0_ddr4_dqs_t, c0_ddr4_dqs_c, c0_ddr4_dm_dbi_n;
    logic eth_rst_n, eth_sgmii_tx_p, eth_sgmii_tx_n, eth_mdc;
    wire eth_mdio;
    logic spi_mosi, spi_ss, spi_clk_o;

    int n_vec = 0;
    int n_err = 0;

    always #5 sys_clk_p = ~sys_clk_p;
    assign sys_clk_n = ~sys_clk_p;

    ariane_xilinx #(.CLKS_PER_BIT(C), .HB_BITS(4), .IDCODE(ID)) dut (
        .sys_clk_p(sys_clk_p), .sys_clk_n(sys_clk_n), .cpu_reset(cpu_reset),
        .sys_rst_n(sys_rst_n), .trst_n(trst_n), .led(led), .rx(rx), .tx(tx),
        .tck(tck), .tms(tms), .tdi(tdi), .tdo(tdo),
        .c0_ddr4_adr(c0_ddr4_adr), .c0_ddr4_ba(c0_ddr4_ba), .c0_ddr4_cke(c0_ddr4_cke),
        .c0_ddr4_cs_n(c0_ddr4_cs_n), .c0_ddr4_odt(c0_ddr4_odt), .c0_ddr4_bg(c0_ddr4_bg),
        .c0_ddr4_reset_n(c0_ddr4_reset_n), .c0_ddr4_act_n(c0_ddr4_act_n),
        .c0_ddr4_ck_t(c0_ddr4_ck_t), .c0_ddr4_ck_c(c0_ddr4_ck_c),
        .c0_ddr4_dq(c0_ddr4_dq), .c0_ddr4_dqs_t(c0_ddr4_dqs_t), .c0_ddr4_dqs_c(c0_ddr4_dqs_c),
        .c0_ddr4_dm_dbi_n(c0_ddr4_dm_dbi_n),
        .eth_rst_n(eth_rst_n), .eth_sgmii_tx_p(eth_sgmii_tx_p), .eth_sgmii_tx_n(eth_sgmii_tx_n),
        .eth_mdc(eth_mdc), .eth_mdio(eth_mdio),
        .eth_sgmii_rxck_p(in_zero), .eth_sgmii_rxck_n(in_zero), .eth_sgmii_rx_p(in_zero),
        .eth_sgmii_rx_n(in_zero), .eth_int_n(in_zero),
        .spi_mosi(spi_mosi), .spi_ss(spi_ss), .spi_clk_o(spi_clk_o), .spi_miso(in_zero)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // tx frame monitor: entries are {stop, data}
    logic [8:0] tx_q[$];
    logic [7:0] mon_b;
    initial begin
        forever begin
            @(negedge sys_clk_p);
            if (tx === 1'b0) begin
                repeat (C / 2) @(negedge sys_clk_p);
                for (int i = 0; i < 8; i++) begin
                    repeat (C) @(negedge sys_clk_p);
                    mon_b[i] = tx;
                end
                repeat (C) @(negedge sys_clk_p);
                tx_q.push_back({tx, mon_b});
            end
        end
    end

    // Called on a negedge; returns on a negedge so calls chain back-to-back
    task automatic uart_send(input logic [7:0] b, input logic stop);
        rx = 1'b0;
        repeat (C) @(negedge sys_clk_p);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (C) @(negedge sys_clk_p);
        end
        rx = stop;
        repeat (C) @(negedge sys_clk_p);
        rx = 1'b1;
    endtask

    task automatic jtag_clk(input logic tms_v, input logic tdi_v, output logic tdo_v);
        tms = tms_v;
        tdi = tdi_v;
        #100;
        tdo_v = tdo;
        tck = 1'b1;
        #100;
        tck = 1'b0;
    endtask

    task automatic goto_shift_dr();
        logic d;
        jtag_clk(1'b1, 1'b0, d);
        jtag_clk(1'b0, 1'b0, d);
        jtag_clk(1'b0, 1'b0, d);
    endtask

    task automatic read_dr32(output logic [31:0] v);
        logic d;
        for (int i = 0; i < 32; i++) begin
            jtag_clk(i == 31, 1'b0, d);
            v[i] = d;
        end
        jtag_clk(1'b1, 1'b0, d);
        jtag_clk(1'b0, 1'b0, d);
    endtask

    task automatic load_ir(input logic [4:0] v, output logic [4:0] cap);
        logic d;
        jtag_clk(1'b1, 1'b0, d);
        jtag_clk(1'b1, 1'b0, d);
        jtag_clk(1'b0, 1'b0, d);
        jtag_clk(1'b0, 1'b0, d);
        for (int i = 0; i < 5; i++) begin
            jtag_clk(i == 4, v[i], d);
            cap[i] = d;
        end
        jtag_clk(1'b1, 1'b0, d);
        jtag_clk(1'b0, 1'b0, d);
    endtask

    typedef struct {
        logic [7:0] data;
        logic       stop;
        logic       echo;
        logic [3:0] nib;
    } uvec_t;
    uvec_t uv[5];

    logic [10:0] park_exp = 11'b0_1_0_1_0_1_0_0_0_1_0;
    logic [31:0] rd;
    logic [4:0] cap;
    logic [8:0] byp;
    logic [7:0] pat;
    logic d, saw_low;

    initial begin
        uv[0] = '{8'hA5, 1'b1, 1'b1, 4'h5};
        uv[1] = '{8'h3C, 1'b0, 1'b0, 4'h5};
        uv[2] = '{8'h00, 1'b1, 1'b1, 4'h0};
        uv[3] = '{8'hFF, 1'b1, 1'b1, 4'hF};
        uv[4] = '{8'h96, 1'b0, 1'b0, 4'hF};

        cpu_reset = 1'b1;
        sys_rst_n = 1'b0;
        #100;
        check("rst_led", 32'(led), 32'h02);
        check("rst_ddr_reset_n", 32'(c0_ddr4_reset_n), 0);
        check("rst_eth_rst_n", 32'(eth_rst_n), 0);
        check("rst_cs_n", 32'(c0_ddr4_cs_n), 32'h3);
        check("rst_tx", 32'(tx), 1);
        check("rst_tdo", 32'(tdo), 0);
        check("parked_pins", 32'({c0_ddr4_cke, c0_ddr4_act_n, c0_ddr4_ck_t, c0_ddr4_ck_c,
              c0_ddr4_odt, spi_ss, spi_clk_o, spi_mosi, eth_sgmii_tx_p, eth_sgmii_tx_n, eth_mdc}),
              32'(park_exp));
        check("parked_adr", 32'({c0_ddr4_adr, c0_ddr4_ba, c0_ddr4_bg}), 0);
        #100;
        cpu_reset = 1'b0;
        sys_rst_n = 1'b1;
        #10 check("rst_led1_1clk", 32'(led[1]), 1);
        #10 check("rst_led1_2clk", 32'(led[1]), 0);
        check("ddr_reset_n_lag", 32'(c0_ddr4_reset_n), 0);
        #10 check("ddr_reset_n_up", 32'(c0_ddr4_reset_n), 1);
        check("eth_rst_n_up", 32'(eth_rst_n), 1);
        check("cs_n_after", 32'(c0_ddr4_cs_n), 32'h3);
        #140 check("hb_lo", 32'(led[0]), 0);
        #10  check("hb_hi", 32'(led[0]), 1);
        #150 check("hb_hi_end", 32'(led[0]), 1);
        #10  check("hb_wrap", 32'(led[0]), 0);

        for (int k = 0; k < 5; k++) begin
            @(negedge sys_clk_p);
            tx_q.delete();
            uart_send(uv[k].data, uv[k].stop);
            repeat (12 * C) @(negedge sys_clk_p);
            if (uv[k].echo) begin
                check("uart_echo_cnt", 32'(tx_q.size()), 1);
                check("uart_echo_frame", 32'((tx_q.size() > 0) ? tx_q[0] : 9'h0), 32'({1'b1, uv[k].data}));
            end else begin
                check("uart_drop_cnt", 32'(tx_q.size()), 0);
            end
            check("uart_nib", 32'(led[7:4]), 32'(uv[k].nib));
            check("uart_ovr_clear", 32'(led[2]), 0);
        end

        @(negedge sys_clk_p);
        tx_q.delete();
        saw_low = 1'b0;
        rx = 1'b0;
        repeat (C / 4) @(negedge sys_clk_p);
        rx = 1'b1;
        for (int i = 0; i < 20 * C; i++) begin
            @(negedge sys_clk_p);
            if (tx !== 1'b1) saw_low = 1'b1;
        end
        check("glitch_tx_idle", 32'(saw_low), 0);
        check("glitch_no_byte", 32'(tx_q.size()), 0);
        check("glitch_nib", 32'(led[7:4]), 32'hF);

        @(negedge sys_clk_p);
        tx_q.delete();
        uart_send(8'h11, 1'b1);
        uart_send(8'h22, 1'b1);
        uart_send(8'h33, 1'b1);
        repeat (12 * C) @(negedge sys_clk_p);
        check("b2b_cnt", 32'(tx_q.size()), 2);
        check("b2b_first", 32'((tx_q.size() > 0) ? tx_q[0] : 9'h0), 32'h111);
        check("b2b_third", 32'((tx_q.size() > 1) ? tx_q[1] : 9'h0), 32'h133);
        check("b2b_ovr", 32'(led[2]), 1);
        check("b2b_nib", 32'(led[7:4]), 32'h3);
        @(negedge sys_clk_p);
        tx_q.delete();
        uart_send(8'h5A, 1'b1);
        repeat (12 * C) @(negedge sys_clk_p);
        check("after_ovr_echo", 32'((tx_q.size() > 0) ? tx_q[0] : 9'h0), 32'h15A);
        check("ovr_sticky", 32'(led[2]), 1);
        check("after_ovr_nib", 32'(led[7:4]), 32'hA);

        for (int i = 0; i < 5; i++) jtag_clk(1'b1, 1'b0, d);
        jtag_clk(1'b0, 1'b0, d);
        goto_shift_dr();
        check("shift_dr_led", 32'(led[3]), 1);
        read_dr32(rd);
        check("idcode", rd, ID);
        check("rti_led", 32'(led[3]), 0);

        load_ir(5'h1F, cap);
        check("ir_capture", 32'(cap), 32'h01);
        pat = 8'hB2;
        goto_shift_dr();
        for (int k = 0; k < 9; k++) begin
            jtag_clk(k == 8, (k < 8) ? pat[k] : 1'b0, d);
            byp[k] = d;
        end
        check("bypass_delay", 32'(byp), 32'({pat, 1'b0}));
        jtag_clk(1'b1, 1'b0, d);
        jtag_clk(1'b0, 1'b0, d);

        // Five tms=1 edges from Shift-DR must land in Test-Logic-Reset and restore IDCODE
        goto_shift_dr();
        for (int i = 0; i < 5; i++) jtag_clk(1'b1, 1'b0, d);
        jtag_clk(1'b0, 1'b0, d);
        goto_shift_dr();
        read_dr32(rd);
        check("idcode_after_tms_reset", rd, ID);

        load_ir(5'h1F, cap);
        goto_shift_dr();
        check("pre_trst_led3", 32'(led[3]), 1);
        trst_n = 1'b0;
        #1 check("trst_led3", 32'(led[3]), 0);
        #20 trst_n = 1'b1;
        jtag_clk(1'b0, 1'b0, d);
        goto_shift_dr();
        read_dr32(rd);
        check("idcode_after_trst", rd, ID);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
